// File: rtl/daq_pkg.sv
// daq_pkg: shared constants, types and helpers for the DAQ write-side scheduler.
//   AW        memory address width, each memory holds 2^AW bins
//   QLOG      log2 of the readout descriptor queue depth
//   desc_t    readout descriptor (best_ad, raw_ad, lb, rb, l1a_num), 2*AW+21 bits
//   wstate_t  write window FSM encoding
//   space_ok  admission check of one memory against its occupancy
package daq_pkg;

   localparam int AW     = 8;
   localparam int QLOG   = 3;
   localparam int QDEPTH = 1 << QLOG;
   localparam int DESC_W = 2 * AW + 21;

   // Full memory size expressed in the occupancy counter width.
   localparam logic [AW:0] MEM_BINS = {1'b1, {AW{1'b0}}};

   typedef struct packed {
      logic [AW-1:0] best_ad;
      logic [AW-1:0] raw_ad;
      logic [3:0]    lb;
      logic [4:0]    rb;
      logic [11:0]   l1a_num;
   } desc_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wstate_t;

   // True when the free bins of a memory can hold the requested window.
   function automatic logic space_ok(input logic [AW:0] used, input logic [AW:0] need);
      return ((MEM_BINS - used) >= need);
   endfunction

endpackage

// File: rtl/daq_desc_queue.sv
// daq_desc_queue: register-file descriptor queue with three pointers.
//   wr  : next free slot, advanced by push
//   pop : head handed to the formatter, advanced by pop while valid
//   rel : oldest popped entry still holding memory, advanced by rel
// An entry keeps its slot until released, so occupancy is wr - rel.
// Ports:
//   clk, hard_rst      clock, synchronous active-high reset
//   push, push_data    enqueue a descriptor (caller guarantees !full)
//   pop                dequeue head when valid
//   rel                release the oldest popped entry when can_rel
//   head               descriptor at the pop pointer
//   rel_lb, rel_rb     window lengths of the entry at the rel pointer
//   valid              head descriptor available (pop != wr)
//   can_rel            a popped, unreleased entry exists (rel != pop)
//   full               all slots held
module daq_desc_queue
   import daq_pkg::*;
(
   input  logic       clk,
   input  logic       hard_rst,
   input  logic       push,
   input  desc_t      push_data,
   input  logic       pop,
   input  logic       rel,
   output desc_t      head,
   output logic [3:0] rel_lb,
   output logic [4:0] rel_rb,
   output logic       valid,
   output logic       can_rel,
   output logic       full
);

   // Pointers carry one extra wrap bit so a full queue differs from an empty one.
   localparam logic [QLOG:0] Q_FULL = {1'b1, {QLOG{1'b0}}};

   logic [QLOG:0] wr_r;
   logic [QLOG:0] pop_r;
   logic [QLOG:0] rel_r;
   logic [QLOG:0] count_s;
   desc_t         mem_r [QDEPTH];
   desc_t         rel_entry_s;

   assign count_s     = wr_r - rel_r;
   assign full        = (count_s == Q_FULL);
   assign valid       = (pop_r != wr_r);
   assign can_rel     = (rel_r != pop_r);
   assign head        = mem_r[pop_r[QLOG-1:0]];
   assign rel_entry_s = mem_r[rel_r[QLOG-1:0]];
   assign rel_lb      = rel_entry_s.lb;
   assign rel_rb      = rel_entry_s.rb;

   // Pointer advance; each pointer only moves when its guard holds.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         wr_r  <= {(QLOG+1){1'b0}};
         pop_r <= {(QLOG+1){1'b0}};
         rel_r <= {(QLOG+1){1'b0}};
      end else begin
         if (push && !full) begin
            wr_r <= wr_r + {{QLOG{1'b0}}, 1'b1};
         end
         if (pop && valid) begin
            pop_r <= pop_r + {{QLOG{1'b0}}, 1'b1};
         end
         if (rel && can_rel) begin
            rel_r <= rel_r + {{QLOG{1'b0}}, 1'b1};
         end
      end
   end

   // Descriptor storage, cleared on reset so stale entries never leak out.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            mem_r[i] <= desc_t'({DESC_W{1'b0}});
         end
      end else if (push && !full) begin
         mem_r[wr_r[QLOG-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/daq_buf_sched.sv
// daq_buf_sched: write-side scheduler for the DAQ best-track and raw-hit
// circular memories. Each delayed L1A is admitted or dropped against
// window-FSM idleness, descriptor queue depth and free memory space.
// Accepted events open a write window and queue a readout descriptor;
// their memory space is returned when the formatter reports read-out.
// Ports:
//   clk, hard_rst          clock, synchronous active-high reset
//   l1a_in                 one-cycle L1A aligned to the delayed data
//   l1a_window             best-track bins per event (LB)
//   fifo_tbins, raw_en     raw bins per event, RB = raw_en ? fifo_tbins : 0
//   best_we, best_adw      best memory write enable / address
//   raw_we, raw_adw        raw memory write enable / address
//   desc_valid/desc_ready  descriptor handshake towards the formatter
//   desc_best_ad/raw_ad    start addresses of the head event
//   desc_lb/rb/l1a_num     window lengths and L1A number of the head event
//   rd_done                oldest popped event fully read, release its space
//   busy                   write window open
//   l1a_drop_cnt           rejected L1As, saturating
//   sched_err              sticky, rd_done with nothing to release
module daq_buf_sched
   import daq_pkg::*;
(
   input  logic          clk,
   input  logic          hard_rst,
   input  logic          l1a_in,
   input  logic [3:0]    l1a_window,
   input  logic [4:0]    fifo_tbins,
   input  logic          raw_en,
   output logic          best_we,
   output logic          raw_we,
   output logic [AW-1:0] best_adw,
   output logic [AW-1:0] raw_adw,
   output logic          desc_valid,
   input  logic          desc_ready,
   output logic [AW-1:0] desc_best_ad,
   output logic [AW-1:0] desc_raw_ad,
   output logic [3:0]    desc_lb,
   output logic [4:0]    desc_rb,
   output logic [11:0]   desc_l1a_num,
   input  logic          rd_done,
   output logic          busy,
   output logic [7:0]    l1a_drop_cnt,
   output logic          sched_err
);

   wstate_t       state_r;
   wstate_t       state_nx_s;
   logic [3:0]    best_left_r;
   logic [4:0]    raw_left_r;
   logic [AW-1:0] best_adw_r;
   logic [AW-1:0] raw_adw_r;
   logic [AW:0]   best_used_r;
   logic [AW:0]   raw_used_r;
   logic [11:0]   l1a_num_r;
   logic [7:0]    drop_r;
   logic          err_r;

   logic [3:0]    lb_s;
   logic [4:0]    rb_s;
   logic          accept_s;
   logic          rel_fire_s;
   logic          best_we_s;
   logic          raw_we_s;
   logic [AW:0]   best_add_s;
   logic [AW:0]   best_sub_s;
   logic [AW:0]   raw_add_s;
   logic [AW:0]   raw_sub_s;

   desc_t         push_data_s;
   desc_t         head_s;
   logic [3:0]    rel_lb_s;
   logic [4:0]    rel_rb_s;
   logic          q_valid_s;
   logic          q_can_rel_s;
   logic          q_full_s;

   assign push_data_s = '{best_ad: best_adw_r, raw_ad: raw_adw_r, lb: lb_s,
                          rb: rb_s, l1a_num: l1a_num_r};

   daq_desc_queue u_queue (
      .clk       (clk),
      .hard_rst  (hard_rst),
      .push      (accept_s),
      .push_data (push_data_s),
      .pop       (desc_ready),
      .rel       (rd_done),
      .head      (head_s),
      .rel_lb    (rel_lb_s),
      .rel_rb    (rel_rb_s),
      .valid     (q_valid_s),
      .can_rel   (q_can_rel_s),
      .full      (q_full_s)
   );

   // Admission decision and the occupancy add/subtract terms for this cycle.
   always_comb begin
      lb_s       = l1a_window;
      rb_s       = 5'd0;
      best_add_s = {(AW+1){1'b0}};
      raw_add_s  = {(AW+1){1'b0}};
      best_sub_s = {(AW+1){1'b0}};
      raw_sub_s  = {(AW+1){1'b0}};
      if (raw_en) begin
         rb_s = fifo_tbins;
      end else begin
         rb_s = 5'd0;
      end
      accept_s = l1a_in && (state_r == ST_IDLE) && !q_full_s &&
                 space_ok(best_used_r, (AW+1)'(lb_s)) &&
                 space_ok(raw_used_r, (AW+1)'(rb_s));
      rel_fire_s = rd_done && q_can_rel_s;
      if (accept_s) begin
         best_add_s = (AW+1)'(lb_s);
         raw_add_s  = (AW+1)'(rb_s);
      end else begin
         best_add_s = {(AW+1){1'b0}};
         raw_add_s  = {(AW+1){1'b0}};
      end
      if (rel_fire_s) begin
         best_sub_s = (AW+1)'(rel_lb_s);
         raw_sub_s  = (AW+1)'(rel_rb_s);
      end else begin
         best_sub_s = {(AW+1){1'b0}};
         raw_sub_s  = {(AW+1){1'b0}};
      end
   end

   // Write window next-state and write enables; the window closes once
   // both remaining counts reach their last write.
   always_comb begin
      state_nx_s = state_r;
      best_we_s  = 1'b0;
      raw_we_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && ((lb_s != 4'd0) || (rb_s != 5'd0))) begin
               state_nx_s = ST_WRITE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            best_we_s = (best_left_r != 4'd0);
            raw_we_s  = (raw_left_r != 5'd0);
            if ((best_left_r <= 4'd1) && (raw_left_r <= 5'd1)) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WRITE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Window state register.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Remaining write counts, loaded on accept and consumed per enable cycle.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         best_left_r <= 4'd0;
         raw_left_r  <= 5'd0;
      end else if (accept_s) begin
         best_left_r <= lb_s;
         raw_left_r  <= rb_s;
      end else begin
         if (best_we_s) begin
            best_left_r <= best_left_r - 4'd1;
         end
         if (raw_we_s) begin
            raw_left_r <= raw_left_r - 5'd1;
         end
      end
   end

   // Write addresses advance after each write and wrap with the memory.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         best_adw_r <= {AW{1'b0}};
         raw_adw_r  <= {AW{1'b0}};
      end else begin
         if (best_we_s) begin
            best_adw_r <= best_adw_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (raw_we_s) begin
            raw_adw_r <= raw_adw_r + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Occupancy takes the net of this cycle's accept and release.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         best_used_r <= {(AW+1){1'b0}};
         raw_used_r  <= {(AW+1){1'b0}};
      end else begin
         best_used_r <= best_used_r + best_add_s - best_sub_s;
         raw_used_r  <= raw_used_r + raw_add_s - raw_sub_s;
      end
   end

   // L1A numbering counts every L1A; drops saturate; error is sticky.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         l1a_num_r <= 12'd0;
         drop_r    <= 8'd0;
         err_r     <= 1'b0;
      end else begin
         if (l1a_in) begin
            l1a_num_r <= l1a_num_r + 12'd1;
         end
         if (l1a_in && !accept_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
         end
         if (rd_done && !q_can_rel_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Descriptor fields read as zero whenever no head is available.
   always_comb begin
      desc_best_ad = {AW{1'b0}};
      desc_raw_ad  = {AW{1'b0}};
      desc_lb      = 4'd0;
      desc_rb      = 5'd0;
      desc_l1a_num = 12'd0;
      if (q_valid_s) begin
         desc_best_ad = head_s.best_ad;
         desc_raw_ad  = head_s.raw_ad;
         desc_lb      = head_s.lb;
         desc_rb      = head_s.rb;
         desc_l1a_num = head_s.l1a_num;
      end else begin
         desc_best_ad = {AW{1'b0}};
         desc_raw_ad  = {AW{1'b0}};
         desc_lb      = 4'd0;
         desc_rb      = 5'd0;
         desc_l1a_num = 12'd0;
      end
   end

   // Enables are masked by reset directly so a reset cuts a window at once.
   assign best_we      = best_we_s & ~hard_rst;
   assign raw_we       = raw_we_s & ~hard_rst;
   assign busy         = (state_r == ST_WRITE) & ~hard_rst;
   assign best_adw     = best_adw_r;
   assign raw_adw      = raw_adw_r;
   assign desc_valid   = q_valid_s;
   assign l1a_drop_cnt = drop_r;
   assign sched_err    = err_r;

endmodule

// File: doc/daq_buf_sched.md
Name: daq_buf_sched

Overview:
- Write-side scheduler for the DAQ best-track and raw-hit circular memories.
- On each delayed L1A it decides admission against free space and queue depth, then drives write enables and write addresses for the window.
- Each accepted event gets a readout descriptor (start addresses, lengths, L1A number) for the DAQ formatter, and its memory space is released when the formatter reports the event read out.

Parameters:
- AW, 8, memory address width; each memory holds 2^AW bins.
- QLOG, 3, log2 of descriptor queue depth (8 entries).

Ports:
- clk  in  1  system clock
- hard_rst  in  1  synchronous reset, active-high
- l1a_in  in  1  one-cycle L1A pulse, already aligned to the delayed data
- l1a_window  in  4  best-track bins per event (LB)
- fifo_tbins  in  5  raw bins per event
- raw_en  in  1  raw readout enabled; RB = raw_en ? fifo_tbins : 0
- best_we  out  1  best memory write enable
- raw_we  out  1  raw memory write enable
- best_adw  out  AW  best memory write address
- raw_adw  out  AW  raw memory write address
- desc_valid  out  1  head descriptor available
- desc_ready  in  1  formatter pops descriptor when desc_valid && desc_ready
- desc_best_ad  out  AW  best start address of head event
- desc_raw_ad  out  AW  raw start address of head event
- desc_lb  out  4  LB captured at accept
- desc_rb  out  5  RB captured at accept
- desc_l1a_num  out  12  L1A number of head event
- rd_done  in  1  oldest popped event has been fully read
- busy  out  1  write window open
- l1a_drop_cnt  out  8  rejected L1As, saturating at 255
- sched_err  out  1  sticky; set by rd_done with no popped, unreleased event

Behaviour:
- Reset values:
  - All outputs 0; best_adw = raw_adw = 0.
  - Occupancy counters, queue pointers and l1a_num cleared.
  - Takes effect the same cycle reset is sampled, so a reset mid-window stops writes immediately.
- L1A numbering: l1a_num is 12 bits and increments on every l1a_in, accepted or rejected, wrapping 4095 -> 0. An event takes the value held before the increment (first event after reset = 0).
- Accept condition (registered in the cycle of l1a_in), all of the following must hold:
  - !busy
  - queue count < 2^QLOG
  - 2^AW - best_used >= LB
  - 2^AW - raw_used >= RB
- On reject: l1a_drop_cnt is incremented (saturating); nothing else changes.
- On accept:
  - Capture LB, RB, current best_adw and raw_adw, and l1a_num into a new queue entry.
  - best_used += LB; raw_used += RB.
- Write window FSM, states IDLE and WRITE:
  - Accept moves IDLE -> WRITE with latency 1 (write enables assert the cycle after l1a_in).
  - best_we is high for exactly LB cycles; raw_we is high for exactly RB cycles. Both start in the same cycle.
  - Each write-enable cycle advances its address by 1 after the write, modulo 2^AW.
  - WRITE -> IDLE after max(LB, RB) cycles.
  - busy = (state == WRITE).
  - If LB = RB = 0: no WRITE state; the descriptor is still queued (empty event).
- Descriptor queue:
  - Circular, with three pointers: wr, pop, rel.
  - desc_valid = (pop != wr). The descriptor becomes visible the cycle after accept.
  - Pop advances pop.
  - rd_done when rel != pop: subtract the rel entry's LB from best_used and its RB from raw_used, then advance rel.
  - rd_done when rel == pop: ignored, and sched_err is set.
  - Queue count = wr - rel, so an entry holds its slot until released.
- Simultaneous events in one cycle: accept, pop and release all apply; the occupancy counters take the net of the add and the subtract.
- Widths: occupancy counters are AW+1 bits and never exceed 2^AW.

Decomposition:
- Shared package daq_pkg:
  - AW, QLOG
  - descriptor record: best_ad, raw_ad, lb, rb, l1a_num (total 2*AW + 21 bits)
  - FSM state encoding
- One sub-module, daq_desc_queue: a register-file queue with wr/pop/rel pointers, count, and full flag.

Test Plan:
- Single event:
  - Stimulus: reset, l1a_window=5, fifo_tbins=7, raw_en=1, one l1a_in.
  - Response: best_we high 5 cycles starting 1 cycle later; raw_we high 7 cycles; descriptor valid with best_ad=0, raw_ad=0, lb=5, rb=7, l1a_num=0; final addresses 5 and 7.
- Busy rejection: l1a_in 3 cycles after the first -> l1a_drop_cnt=1; the next accepted event carries l1a_num=2.
- Queue full: 9 spaced L1As, LB=1, RB=0, no rd_done -> 8 accepted, 9th rejected; pop all 8, 10th still rejected; one rd_done -> next accepted.
- Space and wrap:
  - Stimulus: AW=8, RB=31, repeated events with pop and immediate rd_done.
  - Response: raw_adw wraps 248 -> 23 across event 9; rejection when raw_used > 225 without release.
- Simultaneous: accept, pop and rd_done in the same cycle -> best_used = old + LB_new - LB_released; no glitch on desc_valid.
- Reset mid-window: hard_rst in the 3rd write cycle -> best_we = 0 that cycle; all counters, addresses and desc_valid = 0; a spurious rd_done afterwards sets sched_err.
